// File: rtl/dmem_pkg.sv
// Shared encodings and byte-lane helpers for the byte-enable data-memory controller.
package dmem_pkg;

  localparam logic [1:0] SZ_B = 2'b00;
  localparam logic [1:0] SZ_H = 2'b01;
  localparam logic [1:0] SZ_W = 2'b10;

  localparam logic [1:0] ST_PROG = 2'd0;
  localparam logic [1:0] ST_IDLE = 2'd1;
  localparam logic [1:0] ST_ACC  = 2'd2;

  typedef struct packed {
    logic       we;
    logic [1:0] size;
    logic       uns;
    logic [1:0] off;
    logic       err;
  } acc_req_t;

  // Reserved size 2'b11 falls into the word arm everywhere below.
  function automatic logic misaligned(input logic [1:0] size, input logic [1:0] off);
    case (size)
      SZ_B:    return 1'b0;
      SZ_H:    return off[0];
      default: return off != 2'b00;
    endcase
  endfunction

  function automatic logic [1:0] align_off(input logic [1:0] size, input logic [1:0] off);
    case (size)
      SZ_B:    return off;
      SZ_H:    return {off[1], 1'b0};
      default: return 2'b00;
    endcase
  endfunction

  function automatic logic [3:0] byte_en(input logic [1:0] size, input logic [1:0] off);
    case (size)
      SZ_B:    return 4'b0001 << off;
      SZ_H:    return off[1] ? 4'b1100 : 4'b0011;
      default: return 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] lane_data(input logic [1:0] size, input logic [31:0] d);
    case (size)
      SZ_B:    return {4{d[7:0]}};
      SZ_H:    return {2{d[15:0]}};
      default: return d;
    endcase
  endfunction

  function automatic logic [31:0] load_extract(input logic [31:0] word, input logic [1:0] size,
                                               input logic [1:0] off, input logic uns);
    logic [31:0] shifted;
    logic [15:0] half;
    shifted = word >> {off, 3'b000};
    half    = off[1] ? word[31:16] : word[15:0];
    case (size)
      SZ_B:    return {{24{~uns & shifted[7]}}, shifted[7:0]};
      SZ_H:    return {{16{~uns & half[15]}}, half};
      default: return word;
    endcase
  endfunction

endpackage

// File: rtl/dmem_ram_be.sv
// Single-port 32-bit RAM with per-byte write enables and registered read.
module dmem_ram_be #(
  parameter int ADDR_W = 14
) (
  input  logic              clk,
  input  logic [ADDR_W-1:0] addr,
  input  logic              we,
  input  logic [3:0]        be,
  input  logic [31:0]       wdata,
  output logic [31:0]       rdata
);

  logic [31:0] mem [2**ADDR_W];

  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++)
      if (we && be[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
    rdata <= mem[addr];
  end

endmodule

// File: rtl/dmem_be_ctrl.sv
// Byte/half/word data-memory controller with req/ack handshake and UART programming takeover.
// Optional misaligned-access trap: define DMEM_MISALIGN_TRAP_EN.
module dmem_be_ctrl
  import dmem_pkg::*;
#(
  parameter int ADDR_W  = 14,
  parameter int BASE_LO = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [1:0]        cpu_size,
  input  logic              cpu_unsigned,
  input  logic [31:0]       cpu_addr,
  input  logic [31:0]       cpu_wdata,
  output logic              cpu_ack,
  output logic [31:0]       cpu_rdata,
  output logic              cpu_err,
  output logic              busy,
  input  logic              upg_rst_i,
  input  logic              upg_wen_i,
  input  logic [ADDR_W-1:0] upg_adr_i,
  input  logic [31:0]       upg_dat_i,
  input  logic              upg_done_i
);

  logic [1:0]        state;
  logic              run_q;
  acc_req_t          acc_q;
  logic [31:0]       rdata_q;
  logic [31:0]       ram_rdata;
  logic [31:0]       load_data;
  logic [1:0]        req_off;
  logic              req_mis;
  logic              accept;
  logic [ADDR_W-1:0] ram_addr;
  logic              ram_we;
  logic [3:0]        ram_be;
  logic [31:0]       ram_wdata;
  logic              unused_addr_bits;

  assign unused_addr_bits = ^cpu_addr[31:ADDR_W+BASE_LO];

`ifdef DMEM_MISALIGN_TRAP_EN
  assign req_mis = misaligned(cpu_size, cpu_addr[1:0]);
  assign req_off = cpu_addr[1:0];
`else
  assign req_mis = 1'b0;
  assign req_off = align_off(cpu_size, cpu_addr[1:0]);
`endif

  assign accept = (state == ST_IDLE) && run_q && cpu_req && !rst;

  // The UART owns the RAM port for the whole of PROG; the CPU everywhere else.
  always_comb begin
    ram_addr  = cpu_addr[ADDR_W+BASE_LO-1:BASE_LO];
    ram_we    = accept && cpu_we && !req_mis;
    ram_be    = byte_en(cpu_size, req_off);
    ram_wdata = lane_data(cpu_size, cpu_wdata);
    if (state == ST_PROG) begin
      ram_addr  = upg_adr_i;
      ram_we    = upg_wen_i && !rst;
      ram_be    = 4'b1111;
      ram_wdata = upg_dat_i;
    end
  end

  dmem_ram_be #(.ADDR_W(ADDR_W)) u_ram (
    .clk   (clk),
    .addr  (ram_addr),
    .we    (ram_we),
    .be    (ram_be),
    .wdata (ram_wdata),
    .rdata (ram_rdata)
  );

  always_ff @(posedge clk) run_q <= upg_rst_i | upg_done_i;

  assign load_data = load_extract(ram_rdata, acc_q.size, acc_q.off, acc_q.uns);

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= ST_IDLE;
      acc_q   <= '0;
      rdata_q <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (!run_q) state <= ST_PROG;
          else if (cpu_req) begin
            acc_q <= '{we: cpu_we, size: cpu_size, uns: cpu_unsigned, off: req_off, err: req_mis};
            state <= ST_ACC;
          end
        end
        ST_ACC: begin
          if (!acc_q.we && !acc_q.err) rdata_q <= load_data;
          state <= run_q ? ST_IDLE : ST_PROG;
        end
        ST_PROG: if (run_q) state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  // A reset arriving during ACC suppresses the ack that cycle.
  assign cpu_ack   = (state == ST_ACC) && !rst;
  assign cpu_err   = cpu_ack && acc_q.err;
  assign cpu_rdata = (cpu_ack && !acc_q.we && !acc_q.err) ? load_data : rdata_q;
  assign busy      = (state == ST_PROG) || (state == ST_ACC);

endmodule

// File: tb/tb_dmem_be_ctrl.sv
// Self-checking bench for dmem_be_ctrl: vector table through a scoreboard plus mode/reset sequences.
module tb_dmem_be_ctrl;

  localparam int ADDR_W = 14;
`ifdef DMEM_MISALIGN_TRAP_EN
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif

  typedef struct {
    logic        we;
    logic [1:0]  size;
    logic        uns;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp;
    logic        err;
  } vec_t;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              cpu_req = 1'b0, cpu_we = 1'b0, cpu_unsigned = 1'b0;
  logic [1:0]        cpu_size = 2'b10;
  logic [31:0]       cpu_addr = '0, cpu_wdata = '0;
  logic              cpu_ack, cpu_err, busy;
  logic [31:0]       cpu_rdata;
  logic              upg_rst_i = 1'b1, upg_wen_i = 1'b0, upg_done_i = 1'b0;
  logic [ADDR_W-1:0] upg_adr_i = '0;
  logic [31:0]       upg_dat_i = '0;

  int          total = 0;
  int          bad = 0;
  vec_t        sb_q[$];
  vec_t        vq[$];
  logic [31:0] held = '0;

  always #5 clk = ~clk;

  dmem_be_ctrl #(.ADDR_W(ADDR_W), .BASE_LO(2)) dut (
    .clk(clk), .rst(rst), .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_size(cpu_size),
    .cpu_unsigned(cpu_unsigned), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata), .cpu_err(cpu_err), .busy(busy),
    .upg_rst_i(upg_rst_i), .upg_wen_i(upg_wen_i), .upg_adr_i(upg_adr_i),
    .upg_dat_i(upg_dat_i), .upg_done_i(upg_done_i)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic vec_t mk(input logic we, input logic [1:0] size, input logic uns,
                              input logic [31:0] addr, input logic [31:0] wdata,
                              input logic [31:0] exp, input logic err);
    vec_t v;
    v.we = we; v.size = size; v.uns = uns; v.addr = addr;
    v.wdata = wdata; v.exp = exp; v.err = err;
    return v;
  endfunction

  // Scoreboard: every ack retires the oldest outstanding access.
  always @(negedge clk) begin
    if (cpu_ack === 1'b1) begin
      if (sb_q.size() == 0) begin
        total++; bad++;
        $display("FAIL unexpected_ack: got ack=1 expected ack=0 at %0t", $time);
      end else begin
        vec_t e;
        e = sb_q.pop_front();
        if (!e.we && !e.err) held = e.exp;
        chk("rdata", cpu_rdata, held);
        chk("err", {31'b0, cpu_err}, {31'b0, e.err});
      end
    end
  end

  task automatic access(input vec_t v);
    @(negedge clk);
    cpu_req = 1'b1; cpu_we = v.we; cpu_size = v.size; cpu_unsigned = v.uns;
    cpu_addr = v.addr; cpu_wdata = v.wdata;
    sb_q.push_back(v);
    @(posedge clk); #1;
    cpu_req = 1'b0;
    @(negedge clk);
    chk("ack_latency", {31'b0, cpu_ack}, 32'd1);
    chk("busy_acc", {31'b0, busy}, 32'd1);
    @(negedge clk);
    chk("ack_pulse", {31'b0, cpu_ack}, 32'd0);
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    while (busy !== 1'b0 && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk(name, {31'b0, busy}, 32'd0);
  endtask

  initial begin
    // Stores carry exp=0; the scoreboard checks their rdata against the held value.
    vq.push_back(mk(1, 2'b10, 0, 32'h10,    32'hDEADBEEF, 0, 0));
    vq.push_back(mk(0, 2'b10, 0, 32'h10,    0, 32'hDEADBEEF, 0));
    vq.push_back(mk(0, 2'b10, 0, 32'h10010, 0, 32'hDEADBEEF, 0));
    vq.push_back(mk(0, 2'b11, 0, 32'h10,    0, 32'hDEADBEEF, 0));
    vq.push_back(mk(1, 2'b10, 0, 32'h20,    32'h11223344, 0, 0));
    vq.push_back(mk(1, 2'b00, 0, 32'h21,    32'hAAAAAA80, 0, 0));
    vq.push_back(mk(0, 2'b00, 0, 32'h21,    0, 32'hFFFFFF80, 0));
    vq.push_back(mk(0, 2'b00, 1, 32'h21,    0, 32'h00000080, 0));
    vq.push_back(mk(0, 2'b10, 0, 32'h20,    0, 32'h11228044, 0));
    vq.push_back(mk(0, 2'b00, 0, 32'h23,    0, 32'h00000011, 0));
    vq.push_back(mk(1, 2'b10, 0, 32'h30,    32'h55667788, 0, 0));
    vq.push_back(mk(1, 2'b01, 0, 32'h32,    32'hBEEF8001, 0, 0));
    vq.push_back(mk(0, 2'b01, 0, 32'h32,    0, 32'hFFFF8001, 0));
    vq.push_back(mk(0, 2'b01, 1, 32'h32,    0, 32'h00008001, 0));
    vq.push_back(mk(0, 2'b10, 0, 32'h30,    0, 32'h80017788, 0));
    vq.push_back(mk(0, 2'b00, 0, 32'h30,    0, 32'hFFFFFF88, 0));
    vq.push_back(mk(0, 2'b00, 1, 32'h31,    0, 32'h00000077, 0));
    vq.push_back(mk(0, 2'b01, 0, 32'h30,    0, 32'h00007788, 0));
    vq.push_back(mk(1, 2'b10, 0, 32'h00,    32'hCAFEF00D, 0, 0));
    vq.push_back(mk(0, 2'b10, 0, 32'h00,    0, 32'hCAFEF00D, 0));
    vq.push_back(mk(0, 2'b10, 0, 32'h02,    0, 32'hCAFEF00D, TRAP));
    vq.push_back(mk(1, 2'b01, 0, 32'h03,    32'h00001234, 0, TRAP));
    vq.push_back(mk(0, 2'b10, 0, 32'h00,    0, TRAP ? 32'hCAFEF00D : 32'h1234F00D, 0));

    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_ack", {31'b0, cpu_ack}, 32'd0);
    chk("rst_err", {31'b0, cpu_err}, 32'd0);
    chk("rst_rdata", cpu_rdata, 32'd0);
    chk("rst_busy", {31'b0, busy}, 32'd0);

    foreach (vq[i]) access(vq[i]);

    // UART programming takeover: CPU requests are ignored while busy.
    @(negedge clk);
    upg_rst_i = 1'b0; upg_done_i = 1'b0;
    repeat (3) @(negedge clk);
    chk("prog_busy", {31'b0, busy}, 32'd1);
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_size = 2'b10; cpu_addr = 32'h10;
    repeat (3) @(negedge clk);
    chk("prog_no_ack", {31'b0, cpu_ack}, 32'd0);
    cpu_req = 1'b0;
    upg_wen_i = 1'b1; upg_adr_i = 14'd5; upg_dat_i = 32'h12345678;
    @(negedge clk);
    upg_wen_i = 1'b0; upg_dat_i = '0;
    upg_done_i = 1'b1;
    wait_idle("prog_exit");
    access(mk(0, 2'b10, 0, 32'h14, 0, 32'h12345678, 0));

    // Run->prog while an access is in flight: it still completes, then PROG.
    @(negedge clk);
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_size = 2'b10; cpu_unsigned = 1'b0; cpu_addr = 32'h10;
    sb_q.push_back(mk(0, 2'b10, 0, 32'h10, 0, 32'hDEADBEEF, 0));
    upg_rst_i = 1'b0; upg_done_i = 1'b0;
    @(posedge clk); #1;
    cpu_req = 1'b0;
    @(negedge clk);
    chk("switch_ack", {31'b0, cpu_ack}, 32'd1);
    @(negedge clk);
    chk("switch_prog", {31'b0, busy}, 32'd1);
    chk("switch_no_ack", {31'b0, cpu_ack}, 32'd0);
    upg_rst_i = 1'b1;
    wait_idle("switch_exit");

    // Reset during ACC drops the ack; the committed store survives.
    access(mk(1, 2'b10, 0, 32'h40, 32'hA5A5A5A5, 0, 0));
    @(negedge clk);
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_size = 2'b10; cpu_addr = 32'h40;
    @(posedge clk); #1;
    cpu_req = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    chk("rst_acc_no_ack", {31'b0, cpu_ack}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    held = '0;
    @(negedge clk);
    chk("rst2_ack", {31'b0, cpu_ack}, 32'd0);
    chk("rst2_err", {31'b0, cpu_err}, 32'd0);
    chk("rst2_rdata", cpu_rdata, 32'd0);
    chk("rst2_busy", {31'b0, busy}, 32'd0);
    access(mk(0, 2'b10, 0, 32'h40, 0, 32'hA5A5A5A5, 0));

    repeat (2) @(negedge clk);
    chk("sb_empty", sb_q.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule
